key_debounce_pulse: RTL and testbench

Debounces NUM_KEYS active-low push-buttons and turns each into clean single-cycle event pulses (press, release, long-press) plus a stable debounced level. It sits directly upstream of the IIC 24LC64 read/write controller. key[0] drives the write request (key_wr) and key[1] drives the read request (key_rd). This replaces raw button wiring so the controller only ever sees one request per physical press.

---
 rtl/key_debounce_pulse_pkg.sv | 18 +
 rtl/key_debounce_pulse_if.sv | 29 ++
 rtl/key_debounce_pulse_channel.sv | 120 ++++++++++++
 rtl/key_debounce_pulse.sv | 30 +++
 tb/tb_key_debounce_pulse.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_pulse_pkg.sv
// Shared state encoding and default timing for the key debounce block.
// Defaults assume a 50 MHz clk with a 20 ms debounce window and a 1 s long-press.
package key_debounce_pkg;

   typedef enum logic [1:0] {
      KEY_UP      = 2'd0,
      KEY_FILT_DN = 2'd1,
      KEY_DOWN    = 2'd2,
      KEY_FILT_UP = 2'd3
   } key_state_t;

   localparam int CLK_HZ      = 50_000_000;
   localparam int DEBOUNCE_MS = 20;

   localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;
   localparam int DEFAULT_LONG_CYCLES     = CLK_HZ;

endpackage

// File: rtl/key_debounce_pulse_if.sv
// Raw key pins in, debounced level and event pulses out.
// The master side drives the pins; the slave side is the debouncer.
interface key_debounce_pulse_if #(
   parameter int NUM_KEYS = 2
);

   logic [NUM_KEYS-1:0] key_in;
   logic [NUM_KEYS-1:0] key_level;
   logic [NUM_KEYS-1:0] key_press;
   logic [NUM_KEYS-1:0] key_release;
   logic [NUM_KEYS-1:0] key_long;

   modport master (
      output key_in,
      input  key_level,
      input  key_press,
      input  key_release,
      input  key_long
   );

   modport slave (
      input  key_in,
      output key_level,
      output key_press,
      output key_release,
      output key_long
   );

endinterface

// File: rtl/key_debounce_pulse_channel.sv
// One active-low key: 2-flop synchroniser, debounce FSM, long-press timer.
//
//   state       | meaning
//   ------------+-------------------------------------------------------
//   KEY_UP      | debounced released, waiting for a low pin
//   KEY_FILT_DN | pin low, counting stable cycles before accepting press
//   KEY_DOWN    | debounced pressed, long-press timer running
//   KEY_FILT_UP | pin high, counting stable cycles before accepting release
module key_debounce_channel
   import key_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam int LW = $clog2(LONG_CYCLES + 1);

   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
   localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
   localparam logic [LW-1:0] LONG_ONE  = LW'(1);

   logic          sync1, sync2;
   key_state_t    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] long_q, long_d;
   logic          level_d, press_d, release_d, long_pulse_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1       <= 1'b1;
         sync2       <= 1'b1;
         state_q     <= KEY_UP;
         cnt_q       <= '0;
         long_q      <= '0;
         key_level   <= 1'b1;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
      end else begin
         sync1       <= key_in;
         sync2       <= sync1;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         long_q      <= long_d;
         key_level   <= level_d;
         key_press   <= press_d;
         key_release <= release_d;
         key_long    <= long_pulse_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      long_d       = long_q;
      level_d      = key_level;
      press_d      = 1'b0;
      release_d    = 1'b0;
      long_pulse_d = 1'b0;
      case (state_q)
         KEY_UP: begin
            if (!sync2) begin
               state_d = KEY_FILT_DN;
               cnt_d   = '0;
            end
         end
         KEY_FILT_DN: begin
            if (sync2) begin
               state_d = KEY_UP;
            end else if (cnt_q == CNT_LAST) begin
               state_d = KEY_DOWN;
               cnt_d   = '0;
               press_d = 1'b1;
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         KEY_DOWN: begin
            if (sync2) begin
               state_d = KEY_FILT_UP;
               cnt_d   = '0;
            end else if (long_q != LONG_MAX) begin
               // Saturating at LONG_MAX makes the pulse one-shot per hold.
               long_d       = long_q + LONG_ONE;
               long_pulse_d = (long_q == LONG_LAST);
            end
         end
         KEY_FILT_UP: begin
            // A short high glitch keeps the long timer, so no re-arm.
            if (!sync2) begin
               state_d = KEY_DOWN;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = KEY_UP;
               cnt_d     = '0;
               long_d    = '0;
               release_d = 1'b1;
               level_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = KEY_UP;
         end
      endcase
   end

endmodule

// File: rtl/key_debounce_pulse.sv
// Debounces NUM_KEYS active-low buttons into level plus press/release/long pulses.
// key[0] feeds the EEPROM write request, key[1] the read request.
module key_debounce_pulse
   import key_debounce_pkg::*;
#(
   parameter int NUM_KEYS        = 2,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
   input logic                  clk,
   input logic                  rst_n,
   key_debounce_pulse_if.slave  bus
);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      key_debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .key_in      (bus.key_in[g]),
         .key_level   (bus.key_level[g]),
         .key_press   (bus.key_press[g]),
         .key_release (bus.key_release[g]),
         .key_long    (bus.key_long[g])
      );
   end

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Scoreboard bench: stimulus queues expected pulses with their cycle, a monitor
// matches every observed pulse against the queue; leftovers are missed pulses.
module tb_key_debounce_pulse;

   localparam int NK  = 2;
   localparam int DB  = 10;
   localparam int LG  = 50;
   localparam int LAT = DB + 3;   // pin change at a negedge -> pulse seen at that negedge + LAT

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   checks   = 0;
   int   failures = 0;

   key_debounce_pulse_if #(.NUM_KEYS(NK)) bus ();

   key_debounce_pulse #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (DB),
      .LONG_CYCLES     (LG)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      int kind;
      int ch;
   } ev_t;

   ev_t   exp_q[$];
   string kname[3] = '{"press", "release", "long"};

   task automatic expect_ev(input int kind, input int ch, input int c);
      ev_t e;
      e.cyc  = c;
      e.kind = kind;
      e.ch   = ch;
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %b required %b", name, cyc, act, req);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Monitor: every pulse seen must match a queued expectation at the same cycle.
   initial begin
      logic pulse;
      int   idx;
      forever begin
         @(negedge clk);
         for (int ch = 0; ch < NK; ch++) begin
            for (int k = 0; k < 3; k++) begin
               pulse = (k == 0) ? bus.key_press[ch] :
                       (k == 1) ? bus.key_release[ch] : bus.key_long[ch];
               if (pulse) begin
                  idx = -1;
                  foreach (exp_q[i])
                     if (idx < 0 && exp_q[i].kind == k && exp_q[i].ch == ch) idx = i;
                  checks++;
                  if (idx < 0) begin
                     failures++;
                     $display("FAIL unexpected_%s_ch%0d at cycle %0d: pulse=1 required=0",
                              kname[k], ch, cyc);
                  end else begin
                     if (exp_q[idx].cyc != cyc) begin
                        failures++;
                        $display("FAIL %s_ch%0d: pulse at cycle %0d required cycle %0d",
                                 kname[k], ch, cyc, exp_q[idx].cyc);
                     end
                     exp_q.delete(idx);
                  end
               end
            end
         end
      end
   end

   initial begin
      int c;
      bus.key_in = 2'b11;
      rst_n      = 1'b0;
      @(negedge clk);
      chk("reset_level",   bus.key_level,   2'b11);
      chk("reset_press",   bus.key_press,   2'b00);
      chk("reset_release", bus.key_release, 2'b00);
      chk("reset_long",    bus.key_long,    2'b00);
      wait_until(3);
      rst_n = 1'b1;

      // Idle with keys released.
      wait_until(103);
      chk("idle_level", bus.key_level, 2'b11);

      // Single press on key 0.
      c = cyc;
      bus.key_in[0] = 1'b0;
      expect_ev(0, 0, c + LAT);
      wait_until(c + LAT - 1);
      chk("press0_level_before", bus.key_level, 2'b11);
      wait_until(c + LAT);
      chk("press0_level_after", bus.key_level, 2'b10);
      wait_until(c + 30);
      c = cyc;
      bus.key_in[0] = 1'b1;
      expect_ev(1, 0, c + LAT);
      wait_until(c + LAT - 1);
      chk("release0_level_before", bus.key_level, 2'b10);
      wait_until(c + LAT + 5);
      chk("release0_level_after", bus.key_level, 2'b11);

      // Bounce shorter than the debounce window is rejected.
      for (int i = 0; i < 10; i++) begin
         c = cyc;
         bus.key_in[0] = (i % 2 == 0) ? 1'b0 : 1'b1;
         wait_until(c + 4);
         chk("bounce_level", bus.key_level, 2'b11);
      end
      bus.key_in[0] = 1'b1;
      wait_until(cyc + 20);
      chk("bounce_level_end", bus.key_level, 2'b11);

      // Long hold on key 1: press, one long pulse, release.
      c = cyc;
      bus.key_in[1] = 1'b0;
      expect_ev(0, 1, c + LAT);
      expect_ev(2, 1, c + LAT + LG);
      wait_until(c + 80);
      chk("hold1_level", bus.key_level, 2'b01);
      c = cyc;
      bus.key_in[1] = 1'b1;
      expect_ev(1, 1, c + LAT);
      wait_until(c + LAT + 5);
      chk("hold1_level_after", bus.key_level, 2'b11);

      // Both keys together.
      c = cyc;
      bus.key_in = 2'b00;
      expect_ev(0, 0, c + LAT);
      expect_ev(0, 1, c + LAT);
      wait_until(c + LAT);
      chk("both_press", bus.key_press, 2'b11);
      chk("both_level", bus.key_level, 2'b00);
      wait_until(c + 30);
      c = cyc;
      bus.key_in = 2'b11;
      expect_ev(1, 0, c + LAT);
      expect_ev(1, 1, c + LAT);
      wait_until(c + LAT);
      chk("both_release", bus.key_release, 2'b11);
      wait_until(c + LAT + 5);

      // Reset during a hold, then a fresh press with the pin still low.
      c = cyc;
      bus.key_in[0] = 1'b0;
      expect_ev(0, 0, c + LAT);
      wait_until(c + LAT + 30);
      rst_n = 1'b0;
      #1;
      chk("midhold_reset_level",   bus.key_level,   2'b11);
      chk("midhold_reset_press",   bus.key_press,   2'b00);
      chk("midhold_reset_release", bus.key_release, 2'b00);
      chk("midhold_reset_long",    bus.key_long,    2'b00);
      wait_until(cyc + 3);
      c = cyc;
      rst_n = 1'b1;
      expect_ev(0, 0, c + LAT);
      expect_ev(2, 0, c + LAT + LG);
      wait_until(c + LAT);
      chk("repress_level", bus.key_level, 2'b10);
      wait_until(c + LAT + LG + 5);
      c = cyc;
      bus.key_in[0] = 1'b1;
      expect_ev(1, 0, c + LAT);
      wait_until(c + LAT + 10);

      checks++;
      if (exp_q.size() != 0) begin
         failures += exp_q.size();
         foreach (exp_q[i])
            $display("FAIL missing_%s_ch%0d: no pulse seen, required at cycle %0d",
                     kname[exp_q[i].kind], exp_q[i].ch, exp_q[i].cyc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
